// File: rtl/present_msg_packer.sv
// Byte-stream to 128-bit message packer feeding the PRESENT cipher.
// Pads short messages and chains the IV from returned ciphertext.
module present_msg_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic [19:0]  key_in,
  input  logic [15:0]  iv_in,
  input  logic         iv_load,
  input  logic [127:0] ciphertext_in,
  output logic [127:0] plaintext,
  output logic [19:0]  key,
  output logic [15:0]  init_vec,
  output logic         msg_valid,
  input  logic         msg_ready,
  output logic [4:0]   pad_count
);

  typedef enum logic [1:0] {
    FILL,
    PAD,
    HOLD
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [3:0]     pos;
  logic [3:0]     pos_nx;
  logic [127:0]   pt_nx;
  logic [19:0]    key_nx;
  logic [15:0]    iv_nx;
  logic [4:0]     pad_nx;
  logic           valid_nx;
  logic [6:0]     slot;

  // slot pos lives at [127-8*pos -: 8], i.e. base 8*(15-pos)
  assign slot     = {~pos, 3'b000};
  assign in_ready = (state == FILL) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      pos       <= '0;
      plaintext <= '0;
      key       <= '0;
      init_vec  <= '0;
      pad_count <= '0;
      msg_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      pos       <= pos_nx;
      plaintext <= pt_nx;
      key       <= key_nx;
      init_vec  <= iv_nx;
      pad_count <= pad_nx;
      msg_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    pt_nx    = plaintext;
    key_nx   = key;
    iv_nx    = init_vec;
    pad_nx   = pad_count;
    valid_nx = msg_valid;
    unique case (state)
      FILL: begin
        if (in_valid) begin
          pt_nx[slot +: 8] = in_byte;
          if (pos == 4'd0) key_nx = key_in;
          if (pos == 4'd15) begin
            state_nx = HOLD;
            valid_nx = 1'b1;
            pad_nx   = '0;
          end else if (in_last) begin
            state_nx = PAD;
            pos_nx   = pos + 4'd1;
            pad_nx   = '0;
          end else begin
            pos_nx   = pos + 4'd1;
          end
        end
      end
      PAD: begin
        pt_nx[slot +: 8] = PAD_BYTE;
        pad_nx = pad_count + 5'd1;
        if (pos == 4'd15) begin
          state_nx = HOLD;
          valid_nx = 1'b1;
        end else begin
          pos_nx = pos + 4'd1;
        end
      end
      HOLD: begin
        if (msg_ready) begin
          state_nx = FILL;
          pos_nx   = '0;
          valid_nx = 1'b0;
          pad_nx   = '0;
          iv_nx    = ciphertext_in[15:0];
        end
      end
      default: begin
        state_nx = FILL;
        pos_nx   = '0;
        valid_nx = 1'b0;
      end
    endcase
    // software IV load overrides chaining
    if (iv_load) iv_nx = iv_in;
  end

endmodule
